// File: rtl/lcd_pkg.sv
// Shared LCD definitions: SPI byte types, arbiter state encoding and defaults.
package lcd_pkg;

    // Byte type presented to the SPI transmitter (drives the LCD DC line).
    localparam logic [1:0] SPI_CMD_NONE    = 2'b00;
    localparam logic [1:0] SPI_CMD_COMMAND = 2'b01;  // DC low
    localparam logic [1:0] SPI_CMD_DATA    = 2'b10;  // DC high

    // Longest time a byte may wait for the transmitter before it is aborted.
    localparam int TIMEOUT_CYCLES_DEFAULT = 65535;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        WAIT    = 2'd2
    } arb_state_t;

endpackage

// File: rtl/lcd_rr_picker.sv
// Combinational round-robin picker: one-hot winner, searching cyclically
// from the index after 'last'. Zero when no request is pending.
module lcd_rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [NUM_REQ-1:0] winner
);

    int   idx;
    logic found;

    // First set request after 'last', wrapping; 'last' itself is checked last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_spi_arbiter.sv
// Shares the LCD SPI byte transmitter among NUM_REQ requesters with
// round-robin arbitration, a transaction lock and a per-byte watchdog.
module lcd_spi_arbiter
    import lcd_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int TW             = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_start,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [2*NUM_REQ-1:0] req_cmd,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 err,
    output logic                 busy,
    output logic                 spi_start,
    output logic [7:0]           spi_data,
    output logic [1:0]           spi_cmd,
    input  logic                 spi_ready
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state, state_nxt;
    logic [IW-1:0]      gidx, gidx_nxt;
    logic [IW-1:0]      last, last_nxt;
    logic [TW-1:0]      timer, timer_nxt;
    logic [NUM_REQ-1:0] grant_nxt, req_ready_nxt, winner;
    logic [IW-1:0]      widx;
    logic               err_nxt, busy_nxt, spi_start_nxt;
    logic [7:0]         spi_data_nxt;
    logic [1:0]         spi_cmd_nxt;

    lcd_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .req    (req),
        .last   (last),
        .winner (winner)
    );

    // Binary index of the one-hot winner, kept so the owner can be addressed directly.
    always_comb begin
        widx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) widx = IW'(i);
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt     = state;
        gidx_nxt      = gidx;
        last_nxt      = last;
        timer_nxt     = timer;
        grant_nxt     = grant;
        req_ready_nxt = '0;
        err_nxt       = 1'b0;
        busy_nxt      = busy;
        spi_start_nxt = spi_start;
        spi_data_nxt  = spi_data;
        spi_cmd_nxt   = spi_cmd;
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_nxt = winner;
                    gidx_nxt  = widx;
                    state_nxt = GRANTED;
                end
            end
            GRANTED: begin
                // Release wins over a same-cycle start from the owner.
                if (!req[gidx]) begin
                    grant_nxt = '0;
                    last_nxt  = gidx;
                    state_nxt = IDLE;
                end else if (req_start[gidx]) begin
                    spi_start_nxt = 1'b1;
                    spi_data_nxt  = req_data[int'(gidx)*8 +: 8];
                    spi_cmd_nxt   = req_cmd[int'(gidx)*2 +: 2];
                    timer_nxt     = '0;
                    busy_nxt      = 1'b1;
                    state_nxt     = WAIT;
                end
            end
            WAIT: begin
                if (spi_ready) begin
                    spi_start_nxt       = 1'b0;
                    busy_nxt            = 1'b0;
                    req_ready_nxt[gidx] = 1'b1;
                    state_nxt           = GRANTED;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    spi_start_nxt = 1'b0;
                    busy_nxt      = 1'b0;
                    err_nxt       = 1'b1;
                    grant_nxt     = '0;
                    last_nxt      = gidx;
                    state_nxt     = IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: begin
                grant_nxt     = '0;
                busy_nxt      = 1'b0;
                spi_start_nxt = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the transfer immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gidx      <= '0;
            last      <= IW'(NUM_REQ - 1);
            timer     <= '0;
            grant     <= '0;
            req_ready <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            spi_start <= 1'b0;
            spi_data  <= '0;
            spi_cmd   <= SPI_CMD_NONE;
        end else begin
            state     <= state_nxt;
            gidx      <= gidx_nxt;
            last      <= last_nxt;
            timer     <= timer_nxt;
            grant     <= grant_nxt;
            req_ready <= req_ready_nxt;
            err       <= err_nxt;
            busy      <= busy_nxt;
            spi_start <= spi_start_nxt;
            spi_data  <= spi_data_nxt;
            spi_cmd   <= spi_cmd_nxt;
        end
    end

endmodule

// File: doc/lcd_spi_arbiter.md
Name: lcd_spi_arbiter

Overview:
- Shares the single LCD SPI byte transmitter among NUM_REQ requesters: init sequencer, grid draw engine and text overlay.
- Arbitration is round-robin with a transaction lock. A granted requester keeps the bus until it drops req, so a command byte and its parameter bytes are never interleaved with another requester's bytes.
- A watchdog aborts a byte the transmitter never acknowledges.
- Sits between the draw/init engines and the SPI transmitter.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT_CYCLES, 65535, max cycles spi_start may stay high without spi_ready.
- TW, 16, watchdog counter width; must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- req  in  NUM_REQ  level; requester i wants the bus.
- req_start  in  NUM_REQ  1-cycle pulse; requester i issues a byte.
- req_data  in  8*NUM_REQ  byte of requester i at [8i+7:8i].
- req_cmd  in  2*NUM_REQ  byte type of requester i at [2i+1:2i].
- grant  out  NUM_REQ  one-hot, or zero when idle.
- req_ready  out  NUM_REQ  1-cycle pulse; the byte of requester i completed.
- err  out  1  1-cycle pulse on watchdog abort.
- busy  out  1  high while a byte is in flight (state WAIT).
- spi_start  out  1  level, held until spi_ready.
- spi_data  out  8  byte to the transmitter.
- spi_cmd  out  2  byte type to the transmitter.
- spi_ready  in  1  transmitter byte-done pulse.

Behaviour:
- Reset values, all outputs:
  - grant, req_ready, err, busy, spi_start = 0; spi_data = 0; spi_cmd = 0.
  - Internal: state = IDLE, timer = 0, last = NUM_REQ-1, so index 0 wins first.
- Reset mid-transfer drops spi_start immediately; no ready or err pulse is generated.
- All outputs are registered. Winner selection is combinational from req and last.
- IDLE:
  - If req != 0: grant <= onehot(winner); go to GRANTED. Grant therefore appears 1 cycle after req.
  - Winner = first index with req set, searching cyclically from last+1.
  - spi_ready is ignored in IDLE.
- GRANTED, granted index g:
  - If req[g] == 0: grant <= 0, last <= g, go to IDLE. Release takes priority over a same-cycle req_start[g].
  - Else if req_start[g]: spi_start <= 1, spi_data <= req_data[g], spi_cmd <= req_cmd[g], timer <= 0, busy <= 1; go to WAIT.
  - req_start from non-granted indices is ignored at all times.
- WAIT:
  - If spi_ready: spi_start <= 0, busy <= 0, req_ready[g] <= 1 for exactly one cycle; go to GRANTED.
  - Else if timer == TIMEOUT_CYCLES-1: spi_start <= 0, busy <= 0, err <= 1 for one cycle, grant <= 0, last <= g; go to IDLE.
  - Else timer <= timer + 1.
  - req_start in WAIT is a protocol violation; it is ignored and not queued.
  - req[g] dropping in WAIT does not abort: the byte completes, the ready pulse is sent, then release happens in GRANTED.
- Requester contract: pulse req_start only while grant[i] is high, busy is low and req_ready[i] is low. Back-to-back bytes are possible one cycle after the req_ready pulse.
- Fairness: the index that just released has the lowest priority on the next arbitration.
- Idle gap: at least 1 cycle (IDLE) between one requester's release and the next grant.

Decomposition:
- Shared package lcd_pkg:
  - SPI_CMD_NONE = 2'b00, SPI_CMD_COMMAND = 2'b01 (DC low), SPI_CMD_DATA = 2'b10 (DC high).
  - Arbiter state encoding: IDLE, GRANTED, WAIT.
  - Default TIMEOUT_CYCLES.
- Sub-module lcd_rr_picker (combinational): inputs req and last, outputs a one-hot winner. Reused by the future frame-buffer arbiter.

Test Plan:
- Single requester: req = 3'b001, three bytes 0x2A/cmd 01, 0x00/cmd 10, 0x1D/cmd 10, spi_ready 4 cycles after each start -> grant = 001 one cycle after req; spi_data sequence 2A,00,1D; three req_ready[0] pulses; no err.
- Simultaneous req = 3'b111 after reset, each requester sends 1 byte then drops req -> grant order 001, 010, 100, with one zero-grant cycle between grants.
- Lock: requester 0 granted and sending 5 bytes; req[1] rises after byte 2 -> grant stays 001 until req[0] falls; requester 1 is granted exactly 2 cycles after req[0] falls.
- Fairness: req[0] and req[1] both held high continuously, each releasing (dropping req for one cycle) after 1 byte -> grants alternate 0,1,0,1.
- Timeout: TIMEOUT_CYCLES = 8, spi_ready never asserted -> spi_start high for 8 cycles then low; err pulse; grant = 0; no req_ready.
- Reset mid-WAIT -> spi_start, grant and busy = 0 asynchronously. After reset deasserts with req = 3'b010, grant = 010 on the next cycle.
